pwm_output_stage: RTL and testbench
===================================

PWM_OUTPUT_STAGE -- requirements
Module: pwm_output_stage

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en_out  in  8  per-pin output enable
- en_pwm  in  8  per-pin mode: 1 = PWM, 0 = static high
- sel_3_0  in  8  channel select, pins 3..0, 2 bits per pin
- sel_7_4  in  8  channel select, pins 7..4, 2 bits per pin
- duty_g0c0, duty_g0c1, duty_g1c0, duty_g1c1  in  8 each  duty cycles
- freq_div  in  8  [3:0] = gen0 exponent N0, [7:4] = gen1 exponent N1
- pwm_out  out  8  pin outputs
- period_start  out  2  one-cycle pulse per generator at period start
REQ-002 SHALL treat all inputs as quasi-static register values in the clk domain; no handshake.

Function
REQ-003 SHALL contain two generators, g0 and g1, each with a 16-bit prescaler, an 8-bit period counter and two channels.
REQ-004 Prescaler terminal for gen k SHALL be (2^Nk)-1; tick asserts when prescaler >= terminal, then prescaler clears; otherwise it increments.
REQ-005 N=0 SHALL tick every clk; N=15 SHALL tick every 32768 clks.
REQ-006 Period counter SHALL advance only on tick, counting 0..254 then wrapping to 0 (period = 255 ticks).
REQ-007 Channel raw level SHALL be 1 when period counter < active duty; duty 0 gives constant 0, duty 255 gives constant 1.
REQ-008 period_start[k] SHALL pulse for exactly one clk on the tick where counter wraps 254->0.
REQ-009 The 2-bit select code SHALL map 00 = g0c0, 01 = g0c1, 10 = g1c0, 11 = g1c1; pin i uses bits [2(i mod 4)+1 : 2(i mod 4)] of its select register.
REQ-010 Pin i SHALL be: 0 if en_out[i]=0; 1 if en_out[i]=1 and en_pwm[i]=0; the selected channel level otherwise.
REQ-011 pwm_out SHALL be registered: one clk latency from counter/config change to pin.
REQ-012 Changing en_out, en_pwm or select SHALL take effect on pins after one clk, regardless of period position.
REQ-013 Multiple pins selecting the same channel SHALL output identical waveforms.
REQ-014 Generators SHALL be fully independent; simultaneous ticks or wraps SHALL need no arbitration.

Reset
REQ-015 While rst_n=0: prescalers, period counters, shadow registers, pwm_out and period_start SHALL be 0, asynchronously.
REQ-016 After deassertion, the first tick of each generator SHALL occur 2^Nk clks after the first active edge.
REQ-017 Reset mid-period SHALL abort the period; no partial pulse survives.

Configuration
REQ-018 Macro PWM_SHADOW_EN: when defined, duty and exponent values SHALL be sampled into shadow registers at reset release and on each period_start; active duty/terminal are the shadows, giving glitch-free updates at period boundaries.
REQ-019 Without PWM_SHADOW_EN: duty and exponent inputs SHALL be used directly; changes apply on the next clk, and REQ-004's >= compare guarantees a tick if the terminal shrinks below the current prescaler.

Verification
REQ-020 Scenarios:
- freq_div=0x00, duty_g0c0=0x80, en_out=0x01, en_pwm=0x01, sel=0 -> pin0 high 128 clks, low 127 clks, period 255 clks; period_start[0] every 255 clks.
- duty_g1c1=0x00 and 0xFF, pin7 sel_7_4[7:6]=11, freq_div=0x20 -> pin7 constant 0 / constant 1; period_start[1] every 1020 clks.
- en_out=0xFF, en_pwm=0x00 -> pwm_out=0xFF after one clk; en_out=0x00 -> 0x00.
- PWM_SHADOW_EN defined, duty_g0c0 changed 0x40->0xC0 mid-period -> current period keeps 64-tick high; next period is 192 ticks high. Undefined -> new duty visible within one clk.
- rst_n pulsed low mid-period, freq_div=0x03 -> pwm_out=0 immediately; first tick 8 clks after release.
- All pins sel=01 (g0c1 duty 0x10), en_out=en_pwm=0xFF -> all 8 pins identical, 16 ticks high per 255.

Source files
------------

// File: rtl/pwm_output_stage.sv
// pwm_output_stage: two independent PWM generators, each with a power-of-two prescaler, a
// 255-tick period counter and two duty-compare channels, routed onto eight output pins.
//
// Ports
//   clk             system clock
//   rst_n           asynchronous, active-low reset
//   en_out_i[7:0]   per-pin output enable (0 forces the pin low)
//   en_pwm_i[7:0]   per-pin mode: 1 = selected PWM channel, 0 = static high
//   sel_3_0_i[7:0]  2-bit channel select for pins 3..0 (pin i at bits [2i+1:2i])
//   sel_7_4_i[7:0]  2-bit channel select for pins 7..4 (pin i at bits [2(i-4)+1:2(i-4)])
//                   codes: 00 = g0c0, 01 = g0c1, 10 = g1c0, 11 = g1c1
//   duty_gXcY_i     duty of generator X channel Y, in ticks high per 255-tick period
//   freq_div_i      [3:0] = gen0 prescale exponent N0, [7:4] = gen1 exponent N1
//   pwm_out_o       registered pin outputs
//   period_start_o  one-clk pulse per generator when its counter wraps 254 -> 0
//
// Build option
//   PWM_SHADOW_EN   when defined, duty and exponent are sampled into per-generator shadow
//                   registers at reset release and at each period start, so updates only
//                   take effect on period boundaries. When undefined, inputs act directly.

module pwm_output_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_out_i,
  input  logic [7:0] en_pwm_i,
  input  logic [7:0] sel_3_0_i,
  input  logic [7:0] sel_7_4_i,
  input  logic [7:0] duty_g0c0_i,
  input  logic [7:0] duty_g0c1_i,
  input  logic [7:0] duty_g1c0_i,
  input  logic [7:0] duty_g1c1_i,
  input  logic [7:0] freq_div_i,
  output logic [7:0] pwm_out_o,
  output logic [1:0] period_start_o
);

  localparam int unsigned NumGen  = 2;
  localparam int unsigned NumPins = 8;
  localparam logic [7:0]  CntLast = 8'd254;

  // Per-generator views of the configuration inputs.
  logic [3:0] exp_in   [NumGen];
  logic [7:0] duty0_in [NumGen];
  logic [7:0] duty1_in [NumGen];

  assign exp_in[0]   = freq_div_i[3:0];
  assign exp_in[1]   = freq_div_i[7:4];
  assign duty0_in[0] = duty_g0c0_i;
  assign duty1_in[0] = duty_g0c1_i;
  assign duty0_in[1] = duty_g1c0_i;
  assign duty1_in[1] = duty_g1c1_i;

  // Channel levels in select-code order: {g1c1, g1c0, g0c1, g0c0}.
  logic [3:0]        chan_lvl;
  logic [NumGen-1:0] wrap;

`ifdef PWM_SHADOW_EN
  // High only in the first cycle after reset release; during that cycle the live inputs
  // stand in for the (still zero) shadows so the first period already runs on them.
  logic init_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b1;
    end else begin
      init_q <= 1'b0;
    end
  end
`endif

  for (genvar g = 0; g < NumGen; g++) begin : g_gen
    logic [3:0]  exp_act;
    logic [7:0]  duty0_act;
    logic [7:0]  duty1_act;
    logic [15:0] term;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tick;

`ifdef PWM_SHADOW_EN
    logic [3:0] exp_sh_q;
    logic [7:0] duty0_sh_q;
    logic [7:0] duty1_sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_sh_q   <= '0;
        duty0_sh_q <= '0;
        duty1_sh_q <= '0;
      end else if (init_q || wrap[g]) begin
        // Loaded on the same edge the counter returns to 0, so the new period starts clean.
        exp_sh_q   <= exp_in[g];
        duty0_sh_q <= duty0_in[g];
        duty1_sh_q <= duty1_in[g];
      end
    end

    assign exp_act   = init_q ? exp_in[g]   : exp_sh_q;
    assign duty0_act = init_q ? duty0_in[g] : duty0_sh_q;
    assign duty1_act = init_q ? duty1_in[g] : duty1_sh_q;
`else
    assign exp_act   = exp_in[g];
    assign duty0_act = duty0_in[g];
    assign duty1_act = duty1_in[g];
`endif

    assign term = (16'd1 << exp_act) - 16'd1;
    // >= rather than == so a terminal that shrinks below the running prescaler still ticks.
    assign tick    = (presc_q >= term);
    assign wrap[g] = tick && (cnt_q == CntLast);

    always_comb begin
      presc_d = presc_q + 16'd1;
      cnt_d   = cnt_q;
      if (tick) begin
        presc_d = '0;
        cnt_d   = wrap[g] ? 8'd0 : cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        presc_q <= '0;
        cnt_q   <= '0;
      end else begin
        presc_q <= presc_d;
        cnt_q   <= cnt_d;
      end
    end

    // Counter spans 0..254, so duty 0 never matches and duty 255 always matches.
    assign chan_lvl[2*g]   = (cnt_q < duty0_act);
    assign chan_lvl[2*g+1] = (cnt_q < duty1_act);
  end

  // Pin mux.
  logic [15:0]        sel_all;
  logic [1:0]         pin_code [NumPins];
  logic [NumPins-1:0] pwm_d;

  assign sel_all = {sel_7_4_i, sel_3_0_i};

  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    assign pin_code[i] = sel_all[2*i +: 2];
    assign pwm_d[i]    = en_out_i[i] & (~en_pwm_i[i] | chan_lvl[pin_code[i]]);
  end

  logic [NumPins-1:0] pwm_q;
  logic [NumGen-1:0]  period_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q          <= '0;
      period_start_q <= '0;
    end else begin
      pwm_q          <= pwm_d;
      period_start_q <= wrap;
    end
  end

  assign pwm_out_o      = pwm_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage. Edge k counts posedges after reset release; outputs are
// sampled 1 time unit after each posedge.
module tb_pwm_output_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] en_out = '0;
  logic [7:0] en_pwm = '0;
  logic [7:0] sel_3_0 = '0;
  logic [7:0] sel_7_4 = '0;
  logic [7:0] duty_g0c0 = '0;
  logic [7:0] duty_g0c1 = '0;
  logic [7:0] duty_g1c0 = '0;
  logic [7:0] duty_g1c1 = '0;
  logic [7:0] freq_div = '0;
  logic [7:0] pwm_out;
  logic [1:0] period_start;

  int checks = 0;
  int failures = 0;

  pwm_output_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_out_i       (en_out),
    .en_pwm_i       (en_pwm),
    .sel_3_0_i      (sel_3_0),
    .sel_7_4_i      (sel_7_4),
    .duty_g0c0_i    (duty_g0c0),
    .duty_g0c1_i    (duty_g0c1),
    .duty_g1c0_i    (duty_g1c0),
    .duty_g1c1_i    (duty_g1c1),
    .freq_div_i     (freq_div),
    .pwm_out_o      (pwm_out),
    .period_start_o (period_start)
  );

  always #5 clk = ~clk;

  // Leaves rst_n released at a negedge; the next posedge is edge 1.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 8'h00 || period_start !== 2'b00) begin
      failures++;
      $display("FAIL reset_async: pwm_out=%h period_start=%b expected 00/00", pwm_out, period_start);
    end
    en_out = 8'hFF;
    en_pwm = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 8'h00 || period_start !== 2'b00) begin
      failures++;
      $display("FAIL reset_hold: pwm_out=%h period_start=%b expected 00/00", pwm_out, period_start);
    end
  endtask

  task automatic test_basic();
    int hi, bad, ps0n, ps0_a, ps0_b, ps1n;
    logic expv;
    en_out = 8'h01; en_pwm = 8'h01; sel_3_0 = 8'h00; sel_7_4 = 8'h00;
    duty_g0c0 = 8'h80; freq_div = 8'h00;
    apply_reset();
    hi = 0; bad = 0; ps0n = 0; ps0_a = 0; ps0_b = 0; ps1n = 0;
    for (int k = 1; k <= 510; k++) begin
      @(posedge clk);
      #1;
      expv = (((k - 1) % 255) < 128);
      if (pwm_out[0] !== expv) bad++;
      if (k <= 255 && pwm_out[0] === 1'b1) hi++;
      if (period_start[0] === 1'b1) begin
        ps0n++;
        if (ps0n == 1) ps0_a = k;
        if (ps0n == 2) ps0_b = k;
      end
      if (period_start[1] === 1'b1) ps1n++;
    end
    checks++;
    if (hi != 128) begin
      failures++;
      $display("FAIL basic_high_count: got %0d expected 128", hi);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL basic_waveform: %0d mismatching samples expected 0", bad);
    end
    checks++;
    if (ps0n != 2 || ps0_a != 255 || ps0_b != 510) begin
      failures++;
      $display("FAIL basic_period_start0: n=%0d at %0d,%0d expected 2 at 255,510", ps0n, ps0_a, ps0_b);
    end
    checks++;
    if (ps1n != 2) begin
      failures++;
      $display("FAIL basic_period_start1: n=%0d expected 2", ps1n);
    end
  endtask

  task automatic test_g1_extremes();
    int hi, ps1n, ps1_a, ps1_b, lo;
    en_out = 8'h80; en_pwm = 8'h80; sel_3_0 = 8'h00; sel_7_4 = 8'hC0;
    duty_g1c1 = 8'h00; freq_div = 8'h20;
    apply_reset();
    hi = 0; ps1n = 0; ps1_a = 0; ps1_b = 0;
    for (int k = 1; k <= 2045; k++) begin
      @(posedge clk);
      #1;
      if (pwm_out[7] !== 1'b0) hi++;
      if (period_start[1] === 1'b1) begin
        ps1n++;
        if (ps1n == 1) ps1_a = k;
        if (ps1n == 2) ps1_b = k;
      end
    end
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL g1_duty0: pin7 non-zero in %0d samples expected 0", hi);
    end
    checks++;
    if (ps1n != 2 || ps1_a != 1020 || ps1_b != 2040) begin
      failures++;
      $display("FAIL g1_period_start: n=%0d at %0d,%0d expected 2 at 1020,2040", ps1n, ps1_a, ps1_b);
    end
    duty_g1c1 = 8'hFF;
    apply_reset();
    lo = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (pwm_out[7] !== 1'b1) lo++;
    end
    checks++;
    if (lo != 0) begin
      failures++;
      $display("FAIL g1_duty255: pin7 not high in %0d samples expected 0", lo);
    end
  endtask

  task automatic test_static();
    @(negedge clk);
    en_out = 8'h00; en_pwm = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 8'h00) begin
      failures++;
      $display("FAIL static_off: pwm_out=%h expected 00", pwm_out);
    end
    @(negedge clk);
    en_out = 8'hFF;
    #1;
    checks++;
    if (pwm_out !== 8'h00) begin
      failures++;
      $display("FAIL static_latency: pwm_out=%h before edge expected 00", pwm_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 8'hFF) begin
      failures++;
      $display("FAIL static_on: pwm_out=%h expected ff", pwm_out);
    end
    @(negedge clk);
    en_out = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 8'h00) begin
      failures++;
      $display("FAIL static_disable: pwm_out=%h expected 00", pwm_out);
    end
  endtask

  task automatic test_select_map();
    duty_g0c0 = 8'hFF; duty_g0c1 = 8'h00; duty_g1c0 = 8'hFF; duty_g1c1 = 8'h00;
    freq_div = 8'h00; sel_3_0 = 8'hE4; sel_7_4 = 8'h1B;
    en_out = 8'hFF; en_pwm = 8'hFF;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 8'hA5) begin
      failures++;
      $display("FAIL select_map: pwm_out=%h expected a5", pwm_out);
    end
    @(negedge clk);
    en_out = 8'h0F;
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 8'h05) begin
      failures++;
      $display("FAIL select_en_out: pwm_out=%h expected 05", pwm_out);
    end
    @(negedge clk);
    en_out = 8'hFF; en_pwm = 8'hF0;
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== 8'hAF) begin
      failures++;
      $display("FAIL select_mixed_mode: pwm_out=%h expected af", pwm_out);
    end
  endtask

  task automatic test_duty_update();
    int hi1, hi2, exp1;
    en_out = 8'h01; en_pwm = 8'h01; sel_3_0 = 8'h00; sel_7_4 = 8'h00;
    duty_g0c0 = 8'h40; freq_div = 8'h00;
`ifdef PWM_SHADOW_EN
    exp1 = 64;
`else
    exp1 = 192;
`endif
    apply_reset();
    hi1 = 0; hi2 = 0;
    for (int k = 1; k <= 510; k++) begin
      @(posedge clk);
      #1;
      if (pwm_out[0] === 1'b1) begin
        if (k <= 255) hi1++;
        else hi2++;
      end
      if (k == 30) begin
        @(negedge clk);
        duty_g0c0 = 8'hC0;
      end
    end
    checks++;
    if (hi1 != exp1) begin
      failures++;
      $display("FAIL duty_update_current: high %0d expected %0d", hi1, exp1);
    end
    checks++;
    if (hi2 != 192) begin
      failures++;
      $display("FAIL duty_update_next: high %0d expected 192", hi2);
    end
  endtask

  task automatic test_reset_mid();
    int first_lo;
    en_out = 8'h01; en_pwm = 8'h01; sel_3_0 = 8'h00; sel_7_4 = 8'h00;
    duty_g0c0 = 8'hFF; freq_div = 8'h03;
    apply_reset();
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: pin0=%b expected 1", pwm_out[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 8'h00 || period_start !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_async: pwm_out=%h period_start=%b expected 00/00", pwm_out, period_start);
    end
    duty_g0c0 = 8'h01;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first_lo = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (first_lo == 0 && pwm_out[0] === 1'b0) first_lo = k;
    end
    // Pin stays high while the count is 0; the first tick at edge 8 makes edge 9 low.
    checks++;
    if (first_lo != 9) begin
      failures++;
      $display("FAIL reset_mid_first_tick: first low at edge %0d expected 9", first_lo);
    end
  endtask

  task automatic test_shared_channel();
    int hi0, hi5, split;
    sel_3_0 = 8'h55; sel_7_4 = 8'h55; duty_g0c1 = 8'h10; freq_div = 8'h00;
    en_out = 8'hFF; en_pwm = 8'hFF;
    apply_reset();
    hi0 = 0; hi5 = 0; split = 0;
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk);
      #1;
      if (pwm_out !== 8'h00 && pwm_out !== 8'hFF) split++;
      if (pwm_out[0] === 1'b1) hi0++;
      if (pwm_out[5] === 1'b1) hi5++;
    end
    checks++;
    if (split != 0) begin
      failures++;
      $display("FAIL shared_identical: %0d samples with differing pins expected 0", split);
    end
    checks++;
    if (hi0 != 16 || hi5 != 16) begin
      failures++;
      $display("FAIL shared_high_count: pin0=%0d pin5=%0d expected 16", hi0, hi5);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_g1_extremes();
    test_static();
    test_select_map();
    test_duty_update();
    test_reset_mid();
    test_shared_channel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
